// File: rtl/exc_ctrl.sv
// CP0 register file and exception/interrupt/eret arbiter beside write-back.
// Kills the committing instruction, flushes younger stages and holds a fetch redirect until acked.
module exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [5:0]  wb_exc,
    input  logic        wb_eret,
    input  logic [31:0] wb_badaddr,
    input  logic [5:0]  int_in,
    input  logic        cp0_wen,
    input  logic [7:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [7:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        commit_kill,
    output logic        cancel,
    output logic        exc_valid,
    output logic [31:0] exc_pc,
    input  logic        redirect_ack
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned CODE_W   = 5;
    localparam int unsigned IP_W     = 8;

    localparam logic [XLEN-1:0] EXC_ENTER_ADDR = 32'h0000_0000;

    // {rd, sel} encodings of the implemented registers
    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_COMPARE  = 8'h58;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    localparam logic [CODE_W-1:0] CODE_INT  = 5'd0;
    localparam logic [CODE_W-1:0] CODE_ADEL = 5'd4;
    localparam logic [CODE_W-1:0] CODE_ADES = 5'd5;
    localparam logic [CODE_W-1:0] CODE_SYS  = 5'd8;
    localparam logic [CODE_W-1:0] CODE_BP   = 5'd9;
    localparam logic [CODE_W-1:0] CODE_RI   = 5'd10;
    localparam logic [CODE_W-1:0] CODE_OV   = 5'd12;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IP_W-1:0]   status_im;
    logic              status_exl;
    logic              status_ie;
    logic [1:0]        cause_ip_sw;
    logic [CODE_W-1:0] cause_exc;
    logic [XLEN-1:0]   epc_q;
    logic [XLEN-1:0]   badvaddr_q;
    logic [XLEN-1:0]   count_q;
    logic [XLEN-1:0]   compare_q;
    logic              tick_q;
    logic              timer_pend_q;
    logic [XLEN-1:0]   exc_pc_q;

    logic [IP_W-1:0]   cause_ip;
    logic              int_pend;
    logic              any_exc;
    logic              in_idle;
    logic              trigger;
    logic              take_exc;
    logic              take_eret;
    logic [CODE_W-1:0] exc_code;
    logic              addr_err;
    logic              wr_en;
    logic              wr_status;
    logic              wr_cause;
    logic              wr_epc;
    logic              wr_count;
    logic              wr_compare;

    // Pending view: hardware lines and timer on IP[7:2], software bits on IP[1:0]
    assign cause_ip  = {int_in[5] | timer_pend_q, int_in[4:0], cause_ip_sw};
    assign int_pend  = status_ie & ~status_exl & (|(cause_ip & status_im));
    assign any_exc   = int_pend | (|wb_exc);
    assign in_idle   = (state_q == ST_IDLE);
    assign trigger   = in_idle & wb_valid & (any_exc | wb_eret);
    assign take_exc  = trigger & any_exc;
    assign take_eret = trigger & ~any_exc;

    // Fixed-priority cause selection; interrupts beat every synchronous exception
    always_comb begin
        exc_code = CODE_INT;
        addr_err = 1'b0;
        if (int_pend) begin
            exc_code = CODE_INT;
        end else if (wb_exc[5]) begin
            exc_code = CODE_ADEL;
            addr_err = 1'b1;
        end else if (wb_exc[4]) begin
            exc_code = CODE_RI;
        end else if (wb_exc[3]) begin
            exc_code = CODE_SYS;
        end else if (wb_exc[2]) begin
            exc_code = CODE_BP;
        end else if (wb_exc[1]) begin
            exc_code = CODE_OV;
        end else if (wb_exc[0]) begin
            exc_code = CODE_ADES;
            addr_err = 1'b1;
        end
    end

    // mtc0 is dropped while redirecting and when it collides with a trigger
    always_comb begin
        wr_en      = cp0_wen & in_idle & ~trigger;
        wr_status  = wr_en & (cp0_waddr == ADDR_STATUS);
        wr_cause   = wr_en & (cp0_waddr == ADDR_CAUSE);
        wr_epc     = wr_en & (cp0_waddr == ADDR_EPC);
        wr_count   = wr_en & (cp0_waddr == ADDR_COUNT);
        wr_compare = wr_en & (cp0_waddr == ADDR_COMPARE);
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (trigger)      state_d = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ack) state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; exc_valid decodes straight from the state flop
    always_comb begin
        commit_kill = 1'b0;
        cancel      = 1'b0;
        exc_valid   = 1'b0;
        if (state_q == ST_REDIRECT) begin
            cancel    = 1'b1;
            exc_valid = 1'b1;
        end else if (trigger) begin
            cancel      = 1'b1;
            commit_kill = take_exc;
        end
    end

    // Status: implemented fields IM, EXL, IE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_im  <= '0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (take_exc) begin
            status_exl <= 1'b1;
        end else if (take_eret) begin
            status_exl <= 1'b0;
        end else if (wr_status) begin
            status_im  <= cp0_wdata[15:8];
            status_exl <= cp0_wdata[1];
            status_ie  <= cp0_wdata[0];
        end
    end

    // Cause: ExcCode set by hardware, only IP[1:0] software-writable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_exc   <= '0;
            cause_ip_sw <= '0;
        end else begin
            if (take_exc) begin
                cause_exc <= exc_code;
            end
            if (wr_cause) begin
                cause_ip_sw <= cp0_wdata[9:8];
            end
        end
    end

    // EPC and BadVAddr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            if (take_exc) begin
                epc_q <= wb_pc;
            end else if (wr_epc) begin
                epc_q <= cp0_wdata;
            end
            if (take_exc && addr_err) begin
                badvaddr_q <= wb_badaddr;
            end
        end
    end

    // Count advances every other cycle; a Count write restarts the half-rate phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else if (wr_count) begin
            count_q <= cp0_wdata;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= ~tick_q;
            if (tick_q) begin
                count_q <= count_q + XLEN'(1);
            end
        end
    end

    // Compare and the sticky timer interrupt; a Compare write clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            compare_q    <= '0;
            timer_pend_q <= 1'b0;
        end else if (wr_compare) begin
            compare_q    <= cp0_wdata;
            timer_pend_q <= 1'b0;
        end else if (count_q == compare_q) begin
            timer_pend_q <= 1'b1;
        end
    end

    // Redirect target, captured with the trigger and held through REDIRECT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_pc_q <= '0;
        end else if (take_exc) begin
            exc_pc_q <= EXC_ENTER_ADDR;
        end else if (take_eret) begin
            exc_pc_q <= epc_q;
        end
    end

    assign exc_pc = exc_pc_q;

    // mfc0 read mux
    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            ADDR_BADVADDR: cp0_rdata = badvaddr_q;
            ADDR_COUNT:    cp0_rdata = count_q;
            ADDR_COMPARE:  cp0_rdata = compare_q;
            ADDR_STATUS:   cp0_rdata = {16'h0000, status_im, 6'b000000, status_exl, status_ie};
            ADDR_CAUSE:    cp0_rdata = {16'h0000, cause_ip, 1'b0, cause_exc, 2'b00};
            ADDR_EPC:      cp0_rdata = epc_q;
            default:       cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: behavioural CP0 model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_exc_ctrl;

    localparam logic [7:0] A_BAD = 8'h40;
    localparam logic [7:0] A_CNT = 8'h48;
    localparam logic [7:0] A_CMP = 8'h58;
    localparam logic [7:0] A_STS = 8'h60;
    localparam logic [7:0] A_CAU = 8'h68;
    localparam logic [7:0] A_EPC = 8'h70;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [5:0]  wb_exc;
    logic        wb_eret;
    logic [31:0] wb_badaddr;
    logic [5:0]  int_in;
    logic        cp0_wen;
    logic [7:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [7:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        commit_kill;
    logic        cancel;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic        redirect_ack;

    int checks   = 0;
    int failures = 0;

    exc_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wb_valid     (wb_valid),
        .wb_pc        (wb_pc),
        .wb_exc       (wb_exc),
        .wb_eret      (wb_eret),
        .wb_badaddr   (wb_badaddr),
        .int_in       (int_in),
        .cp0_wen      (cp0_wen),
        .cp0_waddr    (cp0_waddr),
        .cp0_wdata    (cp0_wdata),
        .cp0_raddr    (cp0_raddr),
        .cp0_rdata    (cp0_rdata),
        .commit_kill  (commit_kill),
        .cancel       (cancel),
        .exc_valid    (exc_valid),
        .exc_pc       (exc_pc),
        .redirect_ack (redirect_ack)
    );

    always #5 clk = ~clk;

    // Architectural state of the controller as software sees it
    typedef struct packed {
        logic [7:0]  im;
        logic        exl;
        logic        ie;
        logic [1:0]  ipsw;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] bad;
        logic [31:0] count;
        logic [31:0] cmp;
        logic [31:0] xpc;
        logic        tog;
        logic        tpend;
        logic        redir;
    } mdl_t;

    mdl_t m;

    // Event priority, highest first: interrupt, adel, ri, syscall, break, ov, ades
    int       prio_code [7] = '{0, 4, 10, 8, 9, 12, 5};
    logic [7:0] addr_set [7] = '{8'h40, 8'h48, 8'h58, 8'h60, 8'h68, 8'h70, 8'h10};

    function automatic logic [7:0] m_ip();
        return {int_in[5] | m.tpend, int_in[4:0], m.ipsw};
    endfunction

    function automatic logic m_int_pend();
        return m.ie && !m.exl && ((m_ip() & m.im) != 8'h00);
    endfunction

    function automatic int m_pick();
        logic [6:0] ev;
        ev = {m_int_pend(), wb_exc};
        for (int i = 0; i < 7; i++) begin
            if (ev[6-i]) return prio_code[i];
        end
        return -1;
    endfunction

    function automatic logic m_trig();
        return !m.redir && wb_valid && (m_pick() >= 0 || wb_eret);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            A_BAD:   return m.bad;
            A_CNT:   return m.count;
            A_CMP:   return m.cmp;
            A_STS:   return {16'h0, m.im, 6'h0, m.exl, m.ie};
            A_CAU:   return {16'h0, m_ip(), 1'b0, m.code, 2'b00};
            A_EPC:   return m.epc;
            default: return 32'h0;
        endcase
    endfunction

    // Model advance on each clock edge
    always @(posedge clk or posedge reset) begin : model_step
        mdl_t n;
        int   code;
        logic trig;
        logic wr;
        if (reset) begin
            m <= '0;
        end else begin
            n    = m;
            code = m_pick();
            trig = m_trig();
            wr   = cp0_wen && !m.redir && !trig;
            if (wr && cp0_waddr == A_CNT) begin
                n.count = cp0_wdata;
                n.tog   = 1'b0;
            end else begin
                n.count = m.tog ? m.count + 32'd1 : m.count;
                n.tog   = !m.tog;
            end
            if (wr && cp0_waddr == A_CMP) n.tpend = 1'b0;
            else if (m.count == m.cmp)    n.tpend = 1'b1;
            if (wr) begin
                case (cp0_waddr)
                    A_STS: begin
                        n.im  = cp0_wdata[15:8];
                        n.exl = cp0_wdata[1];
                        n.ie  = cp0_wdata[0];
                    end
                    A_CAU: n.ipsw = cp0_wdata[9:8];
                    A_EPC: n.epc  = cp0_wdata;
                    A_CMP: n.cmp  = cp0_wdata;
                    default: ;
                endcase
            end
            if (trig) begin
                n.redir = 1'b1;
                if (code >= 0) begin
                    n.epc  = wb_pc;
                    n.exl  = 1'b1;
                    n.code = 5'(code);
                    n.xpc  = 32'h0;
                    if (code == 4 || code == 5) n.bad = wb_badaddr;
                end else begin
                    n.exl = 1'b0;
                    n.xpc = m.epc;
                end
            end else if (m.redir && redirect_ack) begin
                n.redir = 1'b0;
            end
            m <= n;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("cancel", 32'(cancel), 32'(m_trig() || m.redir));
            check("commit_kill", 32'(commit_kill), 32'(m_trig() && m_pick() >= 0));
            check("exc_valid", 32'(exc_valid), 32'(m.redir));
            if (m.redir) check("exc_pc", exc_pc, m.xpc);
            check("cp0_rdata", cp0_rdata, m_read(cp0_raddr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid     = 1'b0;
        wb_pc        = 32'h0;
        wb_exc       = 6'h0;
        wb_eret      = 1'b0;
        wb_badaddr   = 32'h0;
        int_in       = 6'h0;
        cp0_wen      = 1'b0;
        cp0_waddr    = 8'h0;
        cp0_wdata    = 32'h0;
        redirect_ack = 1'b0;
    endtask

    task automatic rd(input string name, input logic [7:0] a, input logic [31:0] exp);
        cp0_raddr = a;
        #1;
        check(name, cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
        step();
        idle_inputs();
        cp0_wen   = 1'b1;
        cp0_waddr = a;
        cp0_wdata = d;
    endtask

    // One exception with a single-cycle redirect, then read back the CP0 effects
    task automatic do_exc(input string name, input logic [31:0] pc, input logic [5:0] exc,
                          input logic [31:0] bad, input logic [31:0] exp_cause,
                          input logic [31:0] exp_bad);
        step();
        idle_inputs();
        wb_valid   = 1'b1;
        wb_pc      = pc;
        wb_exc     = exc;
        wb_badaddr = bad;
        @(negedge clk);
        check({name, "_kill"}, 32'(commit_kill), 32'h1);
        step();
        idle_inputs();
        redirect_ack = 1'b1;
        @(negedge clk);
        check({name, "_pc"}, exc_pc, 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        check({name, "_drop"}, 32'(exc_valid), 32'h0);
        rd({name, "_cause"}, A_CAU, exp_cause);
        rd({name, "_bad"}, A_BAD, exp_bad);
        rd({name, "_epc"}, A_EPC, pc);
    endtask

    task automatic rand_inputs();
        wb_valid   = ($urandom_range(0, 1) == 1);
        wb_pc      = $urandom & 32'hFFFF_FFFC;
        wb_exc     = 6'h0;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 9) == 0) wb_exc[i] = 1'b1;
        end
        wb_eret    = ($urandom_range(0, 5) == 0);
        wb_badaddr = $urandom;
        int_in     = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'h0;
        cp0_wen    = ($urandom_range(0, 2) == 0);
        cp0_waddr  = addr_set[$urandom_range(0, 6)];
        cp0_wdata  = $urandom;
        if (cp0_waddr == A_CMP && $urandom_range(0, 1) == 1) cp0_wdata = m.count + 32'($urandom_range(0, 6));
        if (cp0_waddr == A_CNT) cp0_wdata = m.cmp - 32'($urandom_range(0, 6));
        if (cp0_waddr == A_CAU) cp0_wdata = 32'($urandom_range(0, 3)) << 8;
        redirect_ack = ($urandom_range(0, 2) == 0);
        cp0_raddr  = addr_set[$urandom_range(0, 6)];
    endtask

    initial begin : main
        logic seen;
        idle_inputs();
        cp0_raddr = A_STS;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Move Compare away from Count so the timer stays quiet
        cp0_wen   = 1'b1;
        cp0_waddr = A_CMP;
        cp0_wdata = 32'hFFFF_FFFF;
        step();
        idle_inputs();

        // syscall with a held redirect
        step();
        wb_valid = 1'b1;
        wb_pc    = 32'h40;
        wb_exc   = 6'b001000;
        @(negedge clk);
        check("sys_cancel", 32'(cancel), 32'h1);
        check("sys_kill", 32'(commit_kill), 32'h1);
        step();
        idle_inputs();
        repeat (3) begin
            @(negedge clk);
            check("sys_valid", 32'(exc_valid), 32'h1);
            check("sys_pc", exc_pc, 32'h0);
            step();
        end
        redirect_ack = 1'b1;
        @(negedge clk);
        check("sys_hold", 32'(exc_valid), 32'h1);
        step();
        redirect_ack = 1'b0;
        @(negedge clk);
        check("sys_drop", 32'(exc_valid), 32'h0);
        rd("sys_status", A_STS, 32'h2);
        rd("sys_cause", A_CAU, 32'h20);
        rd("sys_epc", A_EPC, 32'h40);

        // eret back to the syscall PC
        step();
        wb_valid = 1'b1;
        wb_eret  = 1'b1;
        @(negedge clk);
        check("eret_kill", 32'(commit_kill), 32'h0);
        check("eret_cancel", 32'(cancel), 32'h1);
        step();
        idle_inputs();
        redirect_ack = 1'b1;
        @(negedge clk);
        check("eret_pc", exc_pc, 32'h40);
        step();
        idle_inputs();
        @(negedge clk);
        rd("eret_status", A_STS, 32'h0);

        // Address errors
        do_exc("adel", 32'h100, 6'b100000, 32'h1003, 32'h10, 32'h1003);
        do_exc("ades", 32'h104, 6'b000001, 32'h2002, 32'h14, 32'h2002);

        // Timer interrupt
        mtc0(A_CNT, 32'h0);
        mtc0(A_CMP, 32'h5);
        mtc0(A_STS, 32'h8001);
        step();
        idle_inputs();
        cp0_raddr = A_CAU;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (cp0_rdata[15]) seen = 1'b1;
            else step();
        end
        check("timer_ip7_wait", 32'(seen), 32'h1);
        rd("timer_cause", A_CAU, 32'h8014);
        rd("timer_count", A_CNT, 32'h5);
        do_exc("tint", 32'h80, 6'b001000, 32'h0, 32'h8000, 32'h2002);
        mtc0(A_CMP, 32'hFFFF_FFFF);
        step();
        idle_inputs();
        @(negedge clk);
        rd("timer_clear", A_CAU, 32'h0);

        // mtc0 colliding with an exception, then a second event during REDIRECT
        step();
        wb_valid  = 1'b1;
        wb_pc     = 32'h200;
        wb_exc    = 6'b000010;
        cp0_wen   = 1'b1;
        cp0_waddr = A_EPC;
        cp0_wdata = 32'h1234;
        @(negedge clk);
        check("col_kill", 32'(commit_kill), 32'h1);
        step();
        wb_pc     = 32'h300;
        wb_exc    = 6'b001000;
        cp0_wdata = 32'h5555;
        @(negedge clk);
        check("col_kill2", 32'(commit_kill), 32'h0);
        check("col_valid", 32'(exc_valid), 32'h1);
        step();
        idle_inputs();
        redirect_ack = 1'b1;
        step();
        idle_inputs();
        @(negedge clk);
        rd("col_epc", A_EPC, 32'h200);
        rd("col_cause", A_CAU, 32'h30);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step();
            rand_inputs();
        end

        // Reset mid-run
        step();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        check("rst_valid", 32'(exc_valid), 32'h0);
        check("rst_pc", exc_pc, 32'h0);
        for (int i = 0; i < 6; i++) rd("rst_reg", addr_set[i], 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            step();
            rand_inputs();
        end
        step();
        idle_inputs();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt controller for the five-stage MIPS pipeline. It sits beside the write-back stage and owns the CP0 register file: Status, Cause, EPC, BadVAddr, Count and Compare. It arbitrates simultaneous exception, interrupt and eret events on the committing instruction, kills that instruction's write-back and flushes younger stages. It then holds a registered redirect to the fetch stage until fetch acknowledges it.

## Interface
- EXC_ENTER_ADDR, 32'h0000_0000: exception/interrupt entry PC.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wb_valid  input  1  WB stage holds a valid instruction this cycle.
- wb_pc  input  32  PC of the WB instruction.
- wb_exc  input  6  exception flags of the WB instruction: {adel, ri, syscall, break, ov, ades}.
- wb_eret  input  1  WB instruction is eret.
- wb_badaddr  input  32  faulting address for adel/ades.
- int_in  input  6  level hardware interrupt lines, mapped to Cause.IP[7:2].
- cp0_wen  input  1  mtc0 commit.
- cp0_waddr  input  8  {rd, sel} of mtc0.
- cp0_wdata  input  32  mtc0 data.
- cp0_raddr  input  8  {rd, sel} for mfc0.
- cp0_rdata  output  32  combinational read data; 0 for unimplemented addresses.
- commit_kill  output  1  suppress register-file/HI/LO write of the WB instruction.
- cancel  output  1  flush the IF–MEM stages.
- exc_valid  output  1  redirect request to fetch (registered).
- exc_pc  output  32  redirect target (registered).
- redirect_ack  input  1  fetch has taken the redirect.

## Operation
- Register fields:
  - Status: IM[15:8], EXL[1] and IE[0] are implemented.
  - Cause: IP[15:8] and ExcCode[6:2]. IP[1:0] are software-writable. IP[6:2] = int_in[4:0]. IP[7] = int_in[5] | timer_pend.
  - EPC, BadVAddr, Count and Compare are full 32-bit registers.
  - Addresses: 8,9,11,12,13,14 with sel 0.
  - BadVAddr is read-only. All other registers are writable, limited to their implemented fields.
- int_pend = IE & ~EXL & |(Cause.IP & Status.IM).
- Trigger occurs in state IDLE when wb_valid and any of int_pend, |wb_exc or wb_eret.
- Priority and resulting ExcCode: int 0 > adel 4 > ri 10 > syscall 8 > break 9 > ov 12 > ades 5 > eret.
- On an exception or interrupt trigger, at the clock edge:
  - EPC ← wb_pc.
  - EXL ← 1.
  - ExcCode ← code.
  - BadVAddr ← wb_badaddr, only for adel/ades.
  - exc_pc ← EXC_ENTER_ADDR.
- On an eret trigger (no other event): EXL ← 0 and exc_pc ← EPC, using the EPC value before the edge.
- Any trigger asserts commit_kill, except eret, which commits normally.
- A cp0_wen in the same cycle as a trigger is ignored entirely.
- FSM:
  - IDLE --trigger--> REDIRECT.
  - REDIRECT --redirect_ack--> IDLE.
  - In REDIRECT, wb_valid and cp0_wen are ignored, and no new trigger is possible.
- Timer:
  - A toggle bit flips every cycle. Count increments when the toggle is 1, wrapping at 2^32.
  - An mtc0 to Count loads the value and clears the toggle.
  - timer_pend is set at the edge where Count == Compare. It is sticky and cleared only by an mtc0 to Compare.
- cancel = trigger | (state == REDIRECT).
- exc_valid = (state == REDIRECT).

## Timing
- Reset values: all CP0 registers 0, timer_pend 0, toggle 0, state IDLE, exc_valid 0, exc_pc 0.
  - commit_kill and cancel are 0 when no trigger is present.
- Trigger in cycle T:
  - commit_kill and cancel assert combinationally in T.
  - CP0 updates at the end of T.
  - exc_valid and exc_pc are valid from T+1.
- exc_valid and exc_pc stay stable until the edge that samples redirect_ack = 1. exc_valid is low the following cycle.
  - Minimum redirect pulse: 1 cycle (ack in T+1 → exc_valid low in T+2).
- redirect_ack is ignored in IDLE.
- Asynchronous reset mid-REDIRECT drops exc_valid immediately and returns the FSM to IDLE.
- An mtc0 takes effect at the edge. cp0_rdata reflects the new value the next cycle; no write-to-read bypass is provided.
- An interrupt enabled by an mtc0 in cycle T can trigger no earlier than T+1.

## Test plan
- Reset: assert reset for 3 cycles mid-run → exc_valid = 0, exc_pc = 0, and cp0_rdata = 0 for all six addresses.
- syscall: wb_valid, wb_pc = 0x40, wb_exc = syscall; hold ack low for 3 cycles.
  - T: cancel and commit_kill = 1.
  - T+1 through T+3: exc_valid = 1, exc_pc = 0x0.
  - Then Status = 0x2, Cause = 0x20, EPC = 0x40.
- eret following the syscall case → exc_pc = 0x40, Status = 0x0, commit_kill = 0.
- Address error: adel with wb_badaddr = 0x1003, pc 0x100 → Cause = 0x10, BadVAddr = 0x1003, EPC = 0x100.
  - ades with 0x2002 → Cause = 0x14.
- Timer interrupt: mtc0 Compare = 5, then Status = 0x8001; count up.
  - Count reaches 5 → Cause.IP7 set.
  - Next wb_valid with pc 0x80 and syscall set → ExcCode 0 (interrupt wins), EPC = 0x80.
  - mtc0 Compare clears IP7.
- Collision: mtc0 EPC = 0x1234 in the same cycle as an ov at pc 0x200 → EPC = 0x200, Cause = 0x30.
  - A second event during REDIRECT is ignored.
